// File: rtl/sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared definitions for the SRAM arbiter slice:
//   - arb_state_e     : arbiter state (ARB_IDLE / ARB_OWN)
//   - CLIENT_*        : client index constants (UART loader, Milestone1, Milestone2)
//   - *_BASE          : SRAM region base addresses for the Y/U/V/RGB buffers
//   - rr_pick()       : round-robin selection starting at a given client
//   - next_client()   : wrap-around successor of a client index
//   - client_onehot() : client index to one-hot client vector
// -----------------------------------------------------------------------------
package sram_arbiter_pkg;

    localparam int NUM_CLIENTS = 3;
    localparam int CLIENT_ID_W = 2;
    localparam int ADDR_W      = 18;
    localparam int DATA_W      = 16;

    localparam int CLIENT_UART = 0;
    localparam int CLIENT_M1   = 1;
    localparam int CLIENT_M2   = 2;

    localparam logic [ADDR_W-1:0] Y_BASE   = 18'd0;
    localparam logic [ADDR_W-1:0] U_BASE   = 18'd38400;
    localparam logic [ADDR_W-1:0] V_BASE   = 18'd57600;
    localparam logic [ADDR_W-1:0] RGB_BASE = 18'd146944;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    typedef logic [CLIENT_ID_W-1:0] client_id_t;

    function automatic client_id_t next_client(input client_id_t c);
        if (c >= client_id_t'(CLIENT_M2)) begin
            return client_id_t'(CLIENT_UART);
        end
        return c + client_id_t'(1);
    endfunction

    // First requesting client found when scanning upward from 'start' with
    // wrap-around. Returns 'start' when nothing is requesting; callers only
    // use the result when at least one request bit is set.
    function automatic client_id_t rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                           input client_id_t start);
        logic [3:0] req_ext;
        client_id_t idx;
        client_id_t pick;
        logic       found;
        req_ext = {1'b0, req};
        idx     = start;
        pick    = start;
        found   = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!found && req_ext[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_client(idx);
        end
        return pick;
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] client_onehot(input client_id_t c);
        logic [3:0] v;
        v = 4'b0001 << c;
        return v[NUM_CLIENTS-1:0];
    endfunction

endpackage

// File: rtl/sram_rd_return_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_return_pipe
// Shift register that carries {valid, owner id} alongside an SRAM read so the
// returning data can be steered to the client that issued it. Entry at the
// input appears at the output exactly LATENCY clock edges later.
// Ports:
//   Clock, Resetn (async, active-low) - clears every stage, dropping reads
//   i_valid / i_id                     - read issued this cycle and its owner
//   o_valid / o_id                     - read data returning this cycle
// -----------------------------------------------------------------------------
module sram_rd_return_pipe #(
    parameter int LATENCY = 2,
    parameter int ID_W    = 2
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            i_valid,
    input  logic [ID_W-1:0] i_id,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);

    logic [LATENCY-1:0]           r_valid;
    logic [LATENCY-1:0][ID_W-1:0] r_id;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_valid <= '0;
            r_id    <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_id[0]    <= i_id;
            for (int s = 1; s < LATENCY; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_id[s]    <= r_id[s-1];
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_id    = r_id[LATENCY-1];

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Round-robin arbiter sharing one SRAM port between three clients
// (bit0 UART loader, bit1 Milestone1, bit2 Milestone2).
//
// Handshake: a client holds i_client_req[i] high for as long as it wants the
// port. An access happens in every cycle where o_client_grant[i] and
// i_client_req[i] are both high; the client must present the address / data /
// we_n for that access in the same cycle and advance them after the edge.
// Dropping the request releases ownership at the next edge, followed by one
// idle cycle before the next owner is granted. Read data comes back on
// o_client_rd_data exactly READ_LATENCY cycles after the read access, flagged
// by o_client_rd_valid[i] for the client that issued it.
//
// Ports:
//   Clock, Resetn            - clock, async active-low reset
//   i_client_req/we_n        - per-client request level and write enable (low)
//   i_client_address         - per-client 18-bit address
//   i_client_write_data      - per-client 16-bit write data
//   o_client_grant           - registered one-hot (or zero) owner
//   o_client_rd_valid        - per-client read return strobe
//   o_client_rd_data         - SRAM read data broadcast
//   o_SRAM_address/write_data/we_n, i_SRAM_read_data - shared SRAM port
//   o_arb_state              - current arbiter state (debug)
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_BURST    = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic                                Clock,
    input  logic                                Resetn,
    input  logic [NUM_CLIENTS-1:0]              i_client_req,
    input  logic [NUM_CLIENTS-1:0]              i_client_we_n,
    input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  i_client_address,
    input  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  i_client_write_data,
    output logic [NUM_CLIENTS-1:0]              o_client_grant,
    output logic [NUM_CLIENTS-1:0]              o_client_rd_valid,
    output logic [DATA_W-1:0]                   o_client_rd_data,
    output logic [ADDR_W-1:0]                   o_SRAM_address,
    output logic [DATA_W-1:0]                   o_SRAM_write_data,
    output logic                                o_SRAM_we_n,
    input  logic [DATA_W-1:0]                   i_SRAM_read_data,
    output arb_state_e                          o_arb_state
);

    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_e                 r_state, w_next_state;
    client_id_t                 r_owner, w_next_owner;
    client_id_t                 r_ptr, w_next_ptr;
    logic [NUM_CLIENTS-1:0]     r_grant, w_next_grant;
    logic [BURST_W-1:0]         r_burst, w_next_burst;
    logic [ADDR_W-1:0]          r_last_addr;

    logic                       w_access;
    logic                       w_other_req;
    logic                       w_burst_last;
    logic [ADDR_W-1:0]          w_sel_addr;
    logic [DATA_W-1:0]          w_sel_wdata;
    logic                       w_sel_we_n;
    logic                       w_pipe_valid;
    client_id_t                 w_pipe_id;

    // r_grant is one-hot of r_owner while in ARB_OWN and zero otherwise, so
    // masking with it both qualifies the access and finds competing requests.
    assign w_access     = |(r_grant & i_client_req);
    assign w_other_req  = |(i_client_req & ~r_grant);
    assign w_burst_last = (r_burst == BURST_LAST);

    // Owner's port signals
    always_comb begin
        w_sel_addr  = i_client_address[CLIENT_UART];
        w_sel_wdata = i_client_write_data[CLIENT_UART];
        w_sel_we_n  = i_client_we_n[CLIENT_UART];
        case (r_owner)
            client_id_t'(CLIENT_M1): begin
                w_sel_addr  = i_client_address[CLIENT_M1];
                w_sel_wdata = i_client_write_data[CLIENT_M1];
                w_sel_we_n  = i_client_we_n[CLIENT_M1];
            end
            client_id_t'(CLIENT_M2): begin
                w_sel_addr  = i_client_address[CLIENT_M2];
                w_sel_wdata = i_client_write_data[CLIENT_M2];
                w_sel_we_n  = i_client_we_n[CLIENT_M2];
            end
            default: ;
        endcase
    end

    // Next-state logic. r_ptr always names the client after the most recent
    // owner, so the scan on the next grant naturally skips the old owner,
    // which also covers the burst-cap hand-over.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_ptr   = r_ptr;
        w_next_burst = r_burst;
        case (r_state)
            ARB_IDLE: begin
                if (|i_client_req) begin
                    w_next_state = ARB_OWN;
                    w_next_owner = rr_pick(i_client_req, r_ptr);
                    w_next_ptr   = next_client(w_next_owner);
                    w_next_burst = '0;
                end
            end
            ARB_OWN: begin
                if (!w_access) begin
                    w_next_state = ARB_IDLE;
                end else if (w_burst_last) begin
                    // Cap reached: hand over if someone is waiting,
                    // otherwise keep going with a fresh count.
                    w_next_burst = '0;
                    if (w_other_req) begin
                        w_next_state = ARB_IDLE;
                    end
                end else begin
                    w_next_burst = r_burst + BURST_W'(1);
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
        w_next_grant = (w_next_state == ARB_OWN) ? client_onehot(w_next_owner) : '0;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= ARB_IDLE;
            r_owner     <= client_id_t'(CLIENT_UART);
            r_ptr       <= client_id_t'(CLIENT_UART);
            r_grant     <= '0;
            r_burst     <= '0;
            r_last_addr <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_ptr   <= w_next_ptr;
            r_grant <= w_next_grant;
            r_burst <= w_next_burst;
            if (w_access) begin
                r_last_addr <= w_sel_addr;
            end
        end
    end

    // Outside an access the address parks on the last issued value so the
    // SRAM address bus does not toggle needlessly.
    assign o_SRAM_address    = w_access ? w_sel_addr : r_last_addr;
    assign o_SRAM_write_data = w_access ? w_sel_wdata : '0;
    assign o_SRAM_we_n       = w_access ? w_sel_we_n : 1'b1;

    sram_rd_return_pipe #(
        .LATENCY (READ_LATENCY),
        .ID_W    (CLIENT_ID_W)
    ) u_rd_pipe (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .i_valid (w_access & w_sel_we_n),
        .i_id    (r_owner),
        .o_valid (w_pipe_valid),
        .o_id    (w_pipe_id)
    );

    assign o_client_rd_valid = w_pipe_valid ? client_onehot(w_pipe_id) : '0;
    assign o_client_rd_data  = i_SRAM_read_data;
    assign o_client_grant    = r_grant;
    assign o_arb_state       = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Bench for sram_arbiter. Two instances share all inputs: dut_a uses the
// default MAX_BURST of 64 and drives the SRAM model, dut_b uses MAX_BURST=4
// for the burst-cap scenario. Read returns of dut_a are checked against a
// queue of {client id, data} entries pushed when each read is driven.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int RD_LAT = 2;

    // ---------------- clock / reset ----------------
    logic Clock;
    logic Resetn;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- stimulus / DUT signals ----------------
    logic [2:0]        req;
    logic [2:0]        we_n;
    logic [2:0][17:0]  addr;
    logic [2:0][15:0]  wdata;

    logic [2:0]  a_grant, a_rd_valid, b_grant, b_rd_valid;
    logic [15:0] a_rd_data, b_rd_data, a_sram_wd, b_sram_wd;
    logic [17:0] a_sram_addr, b_sram_addr;
    logic        a_sram_we_n, b_sram_we_n;
    arb_state_e  a_state, b_state;
    logic [15:0] sram_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    // {client id, read data}
    logic [17:0] exp_q [$];

    sram_arbiter #(.MAX_BURST(64), .READ_LATENCY(RD_LAT)) dut_a (
        .Clock               (Clock),
        .Resetn              (Resetn),
        .i_client_req        (req),
        .i_client_we_n       (we_n),
        .i_client_address    (addr),
        .i_client_write_data (wdata),
        .o_client_grant      (a_grant),
        .o_client_rd_valid   (a_rd_valid),
        .o_client_rd_data    (a_rd_data),
        .o_SRAM_address      (a_sram_addr),
        .o_SRAM_write_data   (a_sram_wd),
        .o_SRAM_we_n         (a_sram_we_n),
        .i_SRAM_read_data    (sram_rd_data),
        .o_arb_state         (a_state)
    );

    sram_arbiter #(.MAX_BURST(4), .READ_LATENCY(RD_LAT)) dut_b (
        .Clock               (Clock),
        .Resetn              (Resetn),
        .i_client_req        (req),
        .i_client_we_n       (we_n),
        .i_client_address    (addr),
        .i_client_write_data (wdata),
        .o_client_grant      (b_grant),
        .o_client_rd_valid   (b_rd_valid),
        .o_client_rd_data    (b_rd_data),
        .o_SRAM_address      (b_sram_addr),
        .o_SRAM_write_data   (b_sram_wd),
        .o_SRAM_we_n         (b_sram_we_n),
        .i_SRAM_read_data    (sram_rd_data),
        .o_arb_state         (b_state)
    );

    // ---------------- SRAM model (2-cycle read latency) ----------------
    logic [15:0] mem [0:262143];
    logic [17:0] rd_a1;
    logic        mem_loaded = 1'b0;

    always @(posedge Clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4; i++) mem[U_BASE + 18'(i)] <= 16'h1000 + 16'(i);
            for (int i = 0; i < 3; i++) mem[V_BASE + 18'(i)] <= 16'h2000 + 16'(i);
            mem_loaded <= 1'b1;
        end else if (a_sram_we_n == 1'b0) begin
            mem[a_sram_addr] <= a_sram_wd;
        end
        rd_a1        <= a_sram_addr;
        sram_rd_data <= mem[rd_a1];
    end

    // ---------------- scoreboard monitor ----------------
    logic [1:0]  mon_id;
    logic [17:0] mon_got, mon_exp;

    always @(negedge Clock) begin
        n_checks++;
        if (!$onehot0(a_grant) || !$onehot0(b_grant)) begin
            n_fail++;
            $display("FAIL grant_exclusive: got a=%b b=%b, required at most one bit", a_grant, b_grant);
        end
        if (a_rd_valid !== 3'b000) begin
            n_checks++;
            case (a_rd_valid)
                3'b001:  mon_id = 2'd0;
                3'b010:  mon_id = 2'd1;
                3'b100:  mon_id = 2'd2;
                default: mon_id = 2'd3;
            endcase
            mon_got = {mon_id, a_rd_data};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=%b data=%h, required no read return", a_rd_valid, a_rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rd_return: got id=%0d data=%h, expected id=%0d data=%h",
                             mon_got[17:16], mon_got[15:0], mon_exp[17:16], mon_exp[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        req    = '0;
        we_n   = '1;
        addr   = '0;
        wdata  = '0;
        tick();
        tick();
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        req    = '0;
        we_n   = '1;
        addr   = '0;
        wdata  = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        n_checks++; if (a_grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b, expected 000", a_grant); end
        n_checks++; if (a_rd_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rd_valid: got %b, expected 000", a_rd_valid); end
        n_checks++; if (a_sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b, expected 1", a_sram_we_n); end
        n_checks++; if (a_sram_addr !== 18'd0) begin n_fail++; $display("FAIL reset_addr: got %h, expected 0", a_sram_addr); end
        n_checks++; if (a_sram_wd !== 16'd0) begin n_fail++; $display("FAIL reset_wdata: got %h, expected 0", a_sram_wd); end
        n_checks++; if (a_state !== ARB_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, expected ARB_IDLE", a_state); end
        n_checks++; if (b_grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant_b: got %b, expected 000", b_grant); end
        // Request while reset is held, then release between edges
        req[0] = 1'b1; we_n[0] = 1'b0; addr[0] = 18'd7; wdata[0] = 16'h5a5a;
        @(negedge Clock);
        n_checks++; if (a_grant !== 3'b000) begin n_fail++; $display("FAIL reset_held_grant: got %b, expected 000", a_grant); end
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        @(negedge Clock);
        n_checks++; if (a_grant !== 3'b000) begin n_fail++; $display("FAIL release_grant_early: got %b, expected 000", a_grant); end
        tick();
        @(negedge Clock);
        n_checks++; if (a_grant !== 3'b001) begin n_fail++; $display("FAIL release_first_grant: got %b, expected 001", a_grant); end
        n_checks++; if (a_sram_we_n !== 1'b0) begin n_fail++; $display("FAIL release_we_n: got %b, expected 0", a_sram_we_n); end
        n_checks++; if (a_sram_addr !== 18'd7 || a_sram_wd !== 16'h5a5a) begin n_fail++; $display("FAIL release_port: got %h/%h, expected 7/5a5a", a_sram_addr, a_sram_wd); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_single_read();
        logic [2:0] eg, ev;
        do_reset();
        req[1] = 1'b1; we_n[1] = 1'b1; addr[1] = U_BASE;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 16'h1000 + 16'(i)});
        for (int c = 0; c < 8; c++) begin
            if (c >= 2 && c <= 4) addr[1] = U_BASE + 18'(c - 1);
            if (c == 5) req[1] = 1'b0;
            eg = (c >= 1 && c <= 5) ? 3'b010 : 3'b000;
            ev = (c >= 3 && c <= 6) ? 3'b010 : 3'b000;
            @(negedge Clock);
            n_checks++; if (a_grant !== eg) begin n_fail++; $display("FAIL single_grant c%0d: got %b, expected %b", c, a_grant, eg); end
            n_checks++; if (a_rd_valid !== ev) begin n_fail++; $display("FAIL single_rd_valid c%0d: got %b, expected %b", c, a_rd_valid, ev); end
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if (a_sram_addr !== U_BASE + 18'(c - 1)) begin n_fail++; $display("FAIL single_addr c%0d: got %0d, expected %0d", c, a_sram_addr, U_BASE + 18'(c - 1)); end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        logic [2:0] eg, ev;
        do_reset();
        req = 3'b111; we_n = 3'b111;
        for (int i = 0; i < 3; i++) begin
            addr[i] = V_BASE + 18'(i);
            exp_q.push_back({2'(i), 16'h2000 + 16'(i)});
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 2) req[0] = 1'b0;
            if (c == 5) req[1] = 1'b0;
            if (c == 8) req[2] = 1'b0;
            eg = (c == 1 || c == 2) ? 3'b001 : (c == 4 || c == 5) ? 3'b010 : (c == 7 || c == 8) ? 3'b100 : 3'b000;
            ev = (c == 3) ? 3'b001 : (c == 6) ? 3'b010 : (c == 9) ? 3'b100 : 3'b000;
            @(negedge Clock);
            n_checks++; if (a_grant !== eg) begin n_fail++; $display("FAIL contention_grant c%0d: got %b, expected %b", c, a_grant, eg); end
            n_checks++; if (a_rd_valid !== ev) begin n_fail++; $display("FAIL contention_rd_valid c%0d: got %b, expected %b", c, a_rd_valid, ev); end
            tick();
        end
    endtask

    task automatic test_burst_cap();
        logic [2:0] eg;
        logic       ew;
        do_reset();
        req = 3'b101; we_n = 3'b000;
        addr[0] = 18'd200; wdata[0] = 16'h0a0a;
        addr[2] = 18'd300; wdata[2] = 16'h0c0c;
        for (int c = 0; c < 8; c++) begin
            eg = (c >= 1 && c <= 4) ? 3'b001 : (c >= 6) ? 3'b100 : 3'b000;
            ew = (c >= 1 && c <= 4) || (c >= 6) ? 1'b0 : 1'b1;
            @(negedge Clock);
            n_checks++; if (b_grant !== eg) begin n_fail++; $display("FAIL burst_grant c%0d: got %b, expected %b", c, b_grant, eg); end
            n_checks++; if (b_sram_we_n !== ew) begin n_fail++; $display("FAIL burst_we_n c%0d: got %b, expected %b", c, b_sram_we_n, ew); end
            if (c >= 1) begin
                n_checks++; if (a_grant !== 3'b001) begin n_fail++; $display("FAIL burst_long_cap c%0d: got %b, expected 001", c, a_grant); end
            end
            tick();
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_write_readback();
        int we_low;
        do_reset();
        we_low = 0;
        req[2] = 1'b1; we_n[2] = 1'b0; addr[2] = RGB_BASE; wdata[2] = 16'hBEEF;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) req[2] = 1'b0;
            if (c == 3) begin
                req[0] = 1'b1; we_n[0] = 1'b1; addr[0] = RGB_BASE;
                exp_q.push_back({2'd0, 16'hBEEF});
            end
            if (c == 5) req[0] = 1'b0;
            @(negedge Clock);
            if (a_sram_we_n === 1'b0) we_low++;
            if (c == 1) begin
                n_checks++; if (a_grant !== 3'b100) begin n_fail++; $display("FAIL wr_grant: got %b, expected 100", a_grant); end
                n_checks++; if (a_sram_we_n !== 1'b0 || a_sram_addr !== RGB_BASE || a_sram_wd !== 16'hBEEF) begin
                    n_fail++; $display("FAIL wr_port: got we_n=%b addr=%0d data=%h, expected 0/%0d/beef", a_sram_we_n, a_sram_addr, a_sram_wd, RGB_BASE);
                end
            end
            if (c == 2) begin
                n_checks++; if (a_sram_we_n !== 1'b1 || a_sram_wd !== 16'h0 || a_sram_addr !== RGB_BASE) begin
                    n_fail++; $display("FAIL wr_idle_port: got we_n=%b addr=%0d data=%h, expected 1/%0d/0", a_sram_we_n, a_sram_addr, a_sram_wd, RGB_BASE);
                end
            end
            if (c == 3) begin
                n_checks++; if (a_grant !== 3'b000) begin n_fail++; $display("FAIL wr_gap: got %b, expected 000", a_grant); end
            end
            if (c == 4) begin
                n_checks++; if (a_grant !== 3'b001) begin n_fail++; $display("FAIL rb_grant: got %b, expected 001", a_grant); end
            end
            if (c == 6) begin
                n_checks++; if (a_rd_valid !== 3'b001) begin n_fail++; $display("FAIL rb_rd_valid: got %b, expected 001", a_rd_valid); end
            end
            tick();
        end
        n_checks++;
        if (we_low != 1) begin n_fail++; $display("FAIL wr_we_n_cycles: got %0d, expected 1", we_low); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req[1] = 1'b1; we_n[1] = 1'b1; addr[1] = U_BASE + 18'd5;
        tick();
        @(negedge Clock);
        n_checks++; if (a_grant !== 3'b010) begin n_fail++; $display("FAIL mid_grant: got %b, expected 010", a_grant); end
        tick();
        Resetn = 1'b0;
        req    = '0;
        @(negedge Clock);
        n_checks++; if (a_grant !== 3'b000 || a_state !== ARB_IDLE) begin n_fail++; $display("FAIL mid_reset_grant: got %b state %0d, expected 000 idle", a_grant, a_state); end
        n_checks++; if (a_sram_we_n !== 1'b1 || a_sram_addr !== 18'd0 || a_sram_wd !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset_port: got we_n=%b addr=%h data=%h, expected 1/0/0", a_sram_we_n, a_sram_addr, a_sram_wd);
        end
        n_checks++; if (a_rd_valid !== 3'b000) begin n_fail++; $display("FAIL mid_reset_rd_valid: got %b, expected 000", a_rd_valid); end
        tick();
        Resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            n_checks++; if (a_rd_valid !== 3'b000) begin n_fail++; $display("FAIL mid_after_rd_valid c%0d: got %b, expected 000", c, a_rd_valid); end
            tick();
        end
    endtask

    task automatic test_lone_requester();
        do_reset();
        req[0] = 1'b1; we_n[0] = 1'b0; addr[0] = 18'd400; wdata[0] = 16'h1234;
        for (int c = 0; c <= 130; c++) begin
            @(negedge Clock);
            if (c >= 1) begin
                n_checks++; if (a_grant !== 3'b001) begin n_fail++; $display("FAIL lone_grant c%0d: got %b, expected 001", c, a_grant); end
                n_checks++; if (b_grant !== 3'b001) begin n_fail++; $display("FAIL lone_grant_cap4 c%0d: got %b, expected 001", c, b_grant); end
            end
            tick();
        end
        req = '0;
        tick();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_burst_cap();
        test_write_readback();
        test_reset_mid();
        test_lone_requester();
        repeat (4) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rd_missing: got %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
